// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial/parallel register stages: FSM state
// encodings and the default word width used by the deserializer and the
// downstream parallel register.
package shift_reg_pkg;

  // Default word width shared with the downstream parallel register stage.
  localparam int DEFAULT_WIDTH = 8;

  // Deserializer framing state.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

endpackage : shift_reg_pkg

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer. Assembles framed serial bits into
// WIDTH-bit words, presents each completed word with a one-cycle load strobe
// for the downstream register, and flags frame_sync slips with sync_err.
module sipo_deserializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       frame_sync,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       load,
  output logic                       sync_err,
  output logic [$clog2(WIDTH)-1:0]   bit_count
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q,  pout_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             load_q,  load_d;
  logic             serr_q,  serr_d;

  // Candidate shift-register images for this cycle's bit: "shifted" appends
  // the bit to the word in progress, "first" starts a fresh word with it.
  // Stale upper/lower bits in "first" are cleared so a word never carries
  // residue from a discarded partial word.
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;

  // Build the shift candidates according to bit order.
  always_comb begin
    shifted = '0;
    first   = '0;
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], serial_in};
      first   = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin
      shifted = {serial_in, shreg_q[WIDTH-1:1]};
      first   = {serial_in, {(WIDTH-1){1'b0}}};
    end
  end

  // Framing FSM: next state, shift register, counter and output strobes.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pout_d  = pout_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    serr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only a sync-marked bit can start framing.
        if (enable && bit_valid && frame_sync) begin
          shreg_d = first;
          cnt_d   = ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!enable) begin
          // Drop the partial word silently; parallel_out keeps its value.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bit_valid) begin
          if (frame_sync) begin
            // Sync wins over word completion; a non-zero count means we
            // were misaligned and the partial word is thrown away.
            shreg_d = first;
            cnt_d   = ONE;
            serr_d  = (cnt_q != '0);
          end else if (cnt_q == LAST) begin
            // Final bit: publish the word and keep framing continuous.
            shreg_d = shifted;
            pout_d  = shifted;
            load_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      pout_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pout_q  <= pout_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      serr_q  <= serr_d;
    end
  end

  assign parallel_out = pout_q;
  assign load         = load_q;
  assign sync_err     = serr_q;
  assign bit_count    = cnt_q;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: directed serial vectors push their
// expected words into a queue; a negedge monitor pops and compares on every
// load, checks the downstream register one cycle later and load spacing.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  // WIDTH=8, MSB first
  logic       enable, serial_in, bit_valid, frame_sync;
  logic [7:0] par8;
  logic       load8, serr8;
  logic [2:0] bc8;
  // WIDTH=4, LSB first
  logic       en4, sin4, v4, s4;
  logic [3:0] par4;
  logic       load4, serr4;
  logic [1:0] bc4;

  // Downstream parallel register model
  logic [7:0] pipo_q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_load   = 0;
  int n_serr   = 0;
  int n_load4  = 0;
  int last_load_cyc = -100;
  int prev_load_cyc = -100;
  logic [7:0] exp_q[$];
  logic [3:0] exp4_q[$];
  logic       pipo_pending = 1'b0;
  logic [7:0] pipo_exp;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .serial_in(serial_in),
    .bit_valid(bit_valid), .frame_sync(frame_sync), .parallel_out(par8),
    .load(load8), .sync_err(serr8), .bit_count(bc8)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .serial_in(sin4),
    .bit_valid(v4), .frame_sync(s4), .parallel_out(par4),
    .load(load4), .sync_err(serr4), .bit_count(bc4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     pipo_q <= '0;
    else if (load8) pipo_q <= par8;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop/compare on load, downstream register, spacing, sync_err count.
  always @(negedge clk) begin
    cyc++;
    if (pipo_pending) begin
      chk("pipo_out", {24'h0, pipo_q}, {24'h0, pipo_exp});
      pipo_pending = 1'b0;
    end
    if (reset && load8) begin
      n_load++;
      if (exp_q.size() == 0) begin
        chk("unexpected_load8", {24'h0, par8}, 32'hFFFF_FFFF);
      end else begin
        pipo_exp = exp_q.pop_front();
        chk("word8", {24'h0, par8}, {24'h0, pipo_exp});
        pipo_pending = 1'b1;
      end
      chk("load_spacing_ok", {31'h0, (cyc - last_load_cyc) >= 8}, 32'd1);
      prev_load_cyc = last_load_cyc;
      last_load_cyc = cyc;
    end
    if (reset && serr8) n_serr++;
    if (reset && load4) begin
      n_load4++;
      if (exp4_q.size() == 0) chk("unexpected_load4", {28'h0, par4}, 32'hFFFF_FFFF);
      else chk("word4", {28'h0, par4}, {28'h0, exp4_q.pop_front()});
    end
  end

  task automatic drive(input logic en, input logic v, input logic b, input logic s);
    enable = en; bit_valid = v; serial_in = b; frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // n bits of pat, MSB of the n-bit field sent first; optional sync on first bit.
  task automatic send_bits(input int n, input logic [31:0] pat, input logic sync_first);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b1, pat[i], sync_first && (i == n - 1));
  endtask

  int l0, s0;
  logic [3:0] v4bits;

  initial begin
    reset = 1'b0;
    enable = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; frame_sync = 1'b0;
    en4 = 1'b0; sin4 = 1'b0; v4 = 1'b0; s4 = 1'b0;
    #12;
    chk("rst_par", {24'h0, par8}, 32'h0);
    chk("rst_load", {31'h0, load8}, 32'h0);
    chk("rst_serr", {31'h0, serr8}, 32'h0);
    chk("rst_bc", {29'h0, bc8}, 32'h0);
    reset = 1'b1;
    idle(2);

    // 1 basic: 1,1,0,0,1,1,0,0
    l0 = n_load; s0 = n_serr;
    exp_q.push_back(8'hCC);
    send_bits(8, 32'hCC, 1'b1);
    chk("t1_load_latency", {31'h0, load8}, 32'd1);
    idle(1);
    chk("t1_load_one_cycle", {31'h0, load8}, 32'd0);
    idle(2);

    // 2 back-to-back, sync only on first bit
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_bits(8, 32'hA5, 1'b1);
    send_bits(8, 32'h3C, 1'b0);
    idle(2);
    chk("t2_spacing", last_load_cyc - prev_load_cyc, 32'd8);
    chk("t2_loads", n_load - l0, 32'd3);

    // 3 gaps, frame_sync without bit_valid during gaps must be ignored
    l0 = n_load;
    exp_q.push_back(8'h81);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, ((8'h81 >> (7 - i)) & 8'h1) != 0, i == 0);
      chk("t3_bc_bit", {29'h0, bc8}, (i + 1) % 8);
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      chk("t3_bc_gap", {29'h0, bc8}, (i + 1) % 8);
    end
    idle(2);
    chk("t3_loads", n_load - l0, 32'd1);
    chk("t3_no_serr", n_serr - s0, 32'd0);

    // 4 resync after 5 bits
    l0 = n_load; s0 = n_serr;
    send_bits(5, 32'h1B, 1'b1);
    exp_q.push_back(8'hF0);
    send_bits(8, 32'hF0, 1'b1);
    idle(2);
    chk("t4_serr", n_serr - s0, 32'd1);
    chk("t4_loads", n_load - l0, 32'd1);

    // 7 sync exactly where the last bit was due
    l0 = n_load; s0 = n_serr;
    send_bits(7, 32'h7F, 1'b1);
    exp_q.push_back(8'h0F);
    send_bits(8, 32'h0F, 1'b1);
    idle(2);
    chk("t7_serr", n_serr - s0, 32'd1);
    chk("t7_loads", n_load - l0, 32'd1);

    // 5a reset mid-word
    send_bits(3, 32'h5, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5_rst_par", {24'h0, par8}, 32'h0);
    chk("t5_rst_bc", {29'h0, bc8}, 32'h0);
    chk("t5_rst_load", {31'h0, load8}, 32'h0);
    #2;
    reset = 1'b1;
    l0 = n_load;
    send_bits(8, 32'hFF, 1'b0);
    idle(2);
    chk("t5_no_word_wo_sync", n_load - l0, 32'd0);
    chk("t5_bc_idle", {29'h0, bc8}, 32'h0);

    // 5b enable drop mid-word
    exp_q.push_back(8'h5A);
    send_bits(8, 32'h5A, 1'b1);
    idle(1);
    l0 = n_load; s0 = n_serr;
    send_bits(3, 32'h7, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_en_bc", {29'h0, bc8}, 32'h0);
    chk("t5_en_par", {24'h0, par8}, 32'h5A);
    send_bits(8, 32'hC3, 1'b0);
    idle(2);
    chk("t5_en_no_load", n_load - l0, 32'd0);
    chk("t5_en_no_serr", n_serr - s0, 32'd0);
    chk("t5_en_par_hold", {24'h0, par8}, 32'h5A);

    // 6 WIDTH=4 LSB first: bits 1,0,0,0 -> 4'h1
    v4bits = 4'b0001;
    exp4_q.push_back(4'h1);
    en4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v4 = 1'b1; sin4 = v4bits[i]; s4 = (i == 0);
      @(posedge clk);
      #1;
    end
    v4 = 1'b0; s4 = 1'b0;
    chk("t6_load4", {31'h0, load4}, 32'd1);
    chk("t6_par4", {28'h0, par4}, 32'h1);
    idle(2);
    chk("t6_loads4", n_load4, 32'd1);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exp4_q_drained", exp4_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sipo_deserializer
